sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Schedules two read clients and one write client onto the 128-row, 2-read/1-write wordline decoder.
//  The write shares decoder slot 1 (address_1) with read port 0, so write and read-0 contend for slot 1.
//  Grants every cycle without conflict, resolves contention round-robin and blocks same-row read/write.
//  Drives the decoder from registered outputs; sits between the client ports and the decoder.
// PARAMETERS
//  ADDR_W  7   row address width; must match the decoder address width
//  CNT_W   16  width of the contention counter (only when SRAM_ARB_STATS_EN is defined)
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  hold          in   1       1 = issue nothing this cycle (all gnt low)
//  rd0_req       in   1       read client 0 request (level)
//  rd0_addr      in   ADDR_W  read client 0 row
//  rd0_gnt       out  1       combinational accept for rd0 (this cycle)
//  rd1_req       in   1       read client 1 request (level)
//  rd1_addr      in   ADDR_W  read client 1 row
//  rd1_gnt       out  1       combinational accept for rd1
//  wr_req        in   1       write client request (level)
//  wr_addr       in   ADDR_W  write row
//  wr_gnt        out  1       combinational accept for write
//  address_1     out  ADDR_W  registered decoder slot-1 address (write or rd0)
//  address_2     out  ADDR_W  registered decoder slot-2 address (rd1, or rd0 when moved)
//  read_enable   out  2       registered decoder read enables {slot2, slot1}
//  write_enable  out  1       registered decoder write enable
//  rd0_on_p2     out  1       registered; 1 = rd0 issued this cycle is on slot 2 (read_wl2)
//  conflict_cnt  out  CNT_W   contention counter (see CONFIGURATION)
// BEHAVIOUR
//  - Handshake: the client holds req and addr stable until it sees gnt=1 at a rising edge; a transfer occurs on req&gnt.
//  - The decoder drives the op exactly 1 cycle after the grant cycle (registered outputs).
//  - The client may drop or replace req in the cycle after the transfer.
//  - gnt depends only on the current req, addr, hold and rr; there is no path from gnt to req.
//  - Arbitration state: 1-bit rr register; rr=0 gives priority to rd0, rr=1 gives priority to the write.
//  - Per-cycle decision, hold=0:
//    * No wr_req: rd0 is granted on slot 1 and rd1 on slot 2, both independently.
//    * wr_req without rd0_req: the write is granted on slot 1 and rd1 on slot 2.
//    * wr_req and rd0_req contend for slot 1:
//      rr=0: rd0 wins slot 1.
//      rr=1: the write wins slot 1, and rd0 moves to slot 2 only if rd1_req=0 (rd0_on_p2=1 next cycle).
//      A loser that cannot be placed gets no gnt.
//    * rr toggles only on a cycle with contention in which exactly one contender was granted.
//  - Row hazard: a read whose addr equals the addr of a write granted in the same cycle is not granted.
//    The write always keeps the slot; the read retries next cycle.
//  - hold=1: all gnt are 0, next-cycle read_enable=0 and write_enable=0, rr unchanged.
//  - Registered outputs:
//    * A slot with no op has its enable low and holds the previous address (no toggling).
//    * read_enable[0] and write_enable are never both 1.
//  - Reset: address_1=0, address_2=0, read_enable=0, write_enable=0, rd0_on_p2=0, rr=0, conflict_cnt=0.
//  - Reset asserted mid-operation clears all outputs asynchronously.
//    Any op granted in the cycle before reset is dropped; clients must re-request after rst falls.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined:
//    conflict_cnt increments by 1 each cycle in which any req is high with its gnt low and hold=0.
//    It saturates at all-ones and clears only on rst.
//  SRAM_ARB_STATS_EN not defined:
//    conflict_cnt is tied to 0 and no counter logic is built. Arbitration is identical in both builds.
// TESTING
//  - After rst, rd0 addr=5 and rd1 addr=9 with no write -> both gnt=1.
//    Next cycle: address_1=5, address_2=9, read_enable=2'b11, write_enable=0.
//  - From rr=0, rd0 addr=3, wr addr=7 and rd1 held for 3 cycles, all req held:
//    cycle 1: rd0 and rd1 granted; cycle 2: write and rd1 granted; write_enable=1 one cycle after that.
//  - rd1 idle, rr=1, wr addr=10, rd0 addr=20 -> both granted.
//    Next cycle: address_1=10, write_enable=1, address_2=20, read_enable=2'b10, rd0_on_p2=1.
//  - rr=1, wr addr=40, rd1 addr=40 -> wr_gnt=1, rd1_gnt=0; rd1 is granted the following cycle with address_2=40.
//  - hold=1 with all requests high for 2 cycles -> no gnt, enables 0, rr unchanged.
//    With SRAM_ARB_STATS_EN defined: conflict_cnt unchanged.
//  - With SRAM_ARB_STATS_EN defined, contend wr and rd0 for 4 cycles -> conflict_cnt=4.
//    Assert rst for 1 cycle mid-stream -> all outputs 0 at once and conflict_cnt=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: schedules two read clients and one write client onto a
// 2-read/1-write wordline decoder. The write shares decoder slot 1 with read
// port 0; contention for slot 1 is resolved round-robin, and a read of the
// row being written in the same cycle is held off.
// Optional build macro: SRAM_ARB_STATS_EN adds a saturating count of cycles
// in which some requester was refused a grant.
module sram_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] address_1,
  output logic [ADDR_W-1:0] address_2,
  output logic [1:0]        read_enable,
  output logic              write_enable,
  output logic              rd0_on_p2,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Round-robin pointer: 0 favours rd0 on slot 1, 1 favours the write.
  logic rr;

  logic contend_p0;
  logic wr_win_p0;
  logic rd0_hz_p0;
  logic rd1_hz_p0;
  logic rd0_s1_p0;
  logic rd0_s2_p0;
  logic rd1_ok_p0;
  logic rr_flip_p0;

  // ---- p0: grant decision, purely from current requests, addresses, hold and rr
  // Decide slot ownership for this cycle; everything stays low under hold.
  always_comb begin
    contend_p0 = 1'b0;
    wr_win_p0  = 1'b0;
    rd0_hz_p0  = 1'b0;
    rd1_hz_p0  = 1'b0;
    rd0_s1_p0  = 1'b0;
    rd0_s2_p0  = 1'b0;
    rd1_ok_p0  = 1'b0;
    rr_flip_p0 = 1'b0;
    if (!hold) begin
      contend_p0 = wr_req & rd0_req;
      // The write takes slot 1 unless rd0 contends while rd0 has priority.
      wr_win_p0  = wr_req & (~rd0_req | rr);
      // A read of the row being written this cycle must wait; the write keeps its slot.
      rd0_hz_p0  = wr_win_p0 & (rd0_addr == wr_addr);
      rd1_hz_p0  = wr_win_p0 & (rd1_addr == wr_addr);
      rd1_ok_p0  = rd1_req & ~rd1_hz_p0;
      // rd0 keeps slot 1 whenever the write does not take it; otherwise it may
      // borrow slot 2, but only when rd1 is not asking for it.
      rd0_s1_p0  = rd0_req & ~wr_win_p0;
      rd0_s2_p0  = rd0_req & wr_win_p0 & ~rd1_req & ~rd0_hz_p0;
      // Hand priority over only when contention left exactly one side served.
      rr_flip_p0 = contend_p0 & (wr_win_p0 ^ (rd0_s1_p0 | rd0_s2_p0));
    end
  end

  assign rd0_gnt = rd0_s1_p0 | rd0_s2_p0;
  assign rd1_gnt = rd1_ok_p0;
  assign wr_gnt  = wr_win_p0;

  // ---- p1: registered decoder drive, one cycle after the grant
  // Load decoder slots from the granted ops; idle slots keep their address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_1    <= '0;
      address_2    <= '0;
      read_enable  <= 2'b00;
      write_enable <= 1'b0;
      rd0_on_p2    <= 1'b0;
      rr           <= 1'b0;
    end else begin
      if (wr_win_p0) begin
        address_1 <= wr_addr;
      end else if (rd0_s1_p0) begin
        address_1 <= rd0_addr;
      end
      if (rd1_ok_p0) begin
        address_2 <= rd1_addr;
      end else if (rd0_s2_p0) begin
        address_2 <= rd0_addr;
      end
      read_enable  <= {rd1_ok_p0 | rd0_s2_p0, rd0_s1_p0};
      write_enable <= wr_win_p0;
      rd0_on_p2    <= rd0_s2_p0;
      if (rr_flip_p0) begin
        rr <= ~rr;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic starved_p0;

  // Increment without wrapping: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign starved_p0 = ~hold & ((rd0_req & ~rd0_gnt) |
                               (rd1_req & ~rd1_gnt) |
                               (wr_req  & ~wr_gnt));

  // Count cycles in which some active requester was turned away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (starved_p0) begin
      conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule
